// File: rtl/gpa_fhdo_seq.sv
// Gradient-update feeder for the GPA-FHDO SPI interface: FIFO, DAC word formatting and valid/busy handshake.
// Optional ADC readback path enabled by defining GPA_FHDO_ADC_READBACK_EN.
module gpa_fhdo_seq #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 255,
  parameter int TWOS_COMP    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   grad_data_i,
  input  logic [1:0]                    grad_ch_i,
  input  logic                          grad_valid_i,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [31:0]                   data_o,
  output logic                          valid_o,
  input  logic                          busy_i,
  input  logic                          adc_req_i,
  input  logic [23:0]                   adc_cmd_i,
  input  logic [15:0]                   adc_value_i,
  output logic [15:0]                   adc_value_o,
  output logic                          adc_valid_o,
  output logic                          overflow_o,
  output logic                          timeout_o,
  input  logic                          clr_err_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q;
  logic [17:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [TW-1:0]   ctr_q;
  logic [31:0]     data_q;
  logic            valid_q, overflow_q, timeout_q, is_adc_q;
  logic            adc_pend_q;
  logic [23:0]     adc_cmd_q;

  logic full, pop, push, ovf_evt, tmo_evt, adc_issue;

  function automatic logic [31:0] dac_word(input logic [17:0] entry);
    logic [15:0] d;
    d = entry[15:0];
    if (TWOS_COMP != 0) d[15] = ~d[15];
    return {12'h000, 2'b10, entry[17:16], d};
  endfunction

  // ADC requests take priority over queued DAC words.
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign adc_issue = (state_q == IDLE) && !busy_i && adc_pend_q;
  assign pop       = (state_q == IDLE) && !busy_i && !adc_pend_q && (count_q != '0);
  assign push      = grad_valid_i && (!full || pop);
  assign ovf_evt   = grad_valid_i && full && !pop;
  assign tmo_evt   = (state_q == WAIT_HI) && !busy_i && (ctr_q == TW'(BUSY_TIMEOUT));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grad_ch_i, grad_data_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ctr_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      is_adc_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      if (ovf_evt)        overflow_q <= 1'b1;
      else if (clr_err_i) overflow_q <= 1'b0;
      if (tmo_evt)        timeout_q  <= 1'b1;
      else if (clr_err_i) timeout_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (adc_issue) begin
            data_q   <= {8'h40, adc_cmd_q};
            is_adc_q <= 1'b1;
            state_q  <= ISSUE;
          end else if (pop) begin
            data_q   <= dac_word(mem_q[rd_ptr_q]);
            is_adc_q <= 1'b0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          valid_q <= 1'b1;
          ctr_q   <= '0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (busy_i)       state_q <= WAIT_LO;
          else if (tmo_evt) state_q <= IDLE;
          else              ctr_q   <= ctr_q + 1'b1;
        end
        default: begin
          if (!busy_i) state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef GPA_FHDO_ADC_READBACK_EN
  logic [15:0] adc_value_q;
  logic        adc_valid_q;

  // A request arriving while one is pending merges into it; the latest command is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_pend_q  <= 1'b0;
      adc_cmd_q   <= '0;
      adc_value_q <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      adc_valid_q <= 1'b0;
      if (adc_req_i) begin
        adc_pend_q <= 1'b1;
        adc_cmd_q  <= adc_cmd_i;
      end else if (adc_issue) begin
        adc_pend_q <= 1'b0;
      end
      if ((state_q == WAIT_LO) && !busy_i && is_adc_q) begin
        adc_value_q <= adc_value_i;
        adc_valid_q <= 1'b1;
      end
    end
  end

  assign adc_value_o = adc_value_q;
  assign adc_valid_o = adc_valid_q;
`else
  logic unused_adc;
  assign unused_adc  = ^{adc_req_i, adc_cmd_i, adc_value_i, is_adc_q};
  assign adc_pend_q  = 1'b0;
  assign adc_cmd_q   = '0;
  assign adc_value_o = '0;
  assign adc_valid_o = 1'b0;
`endif

  assign fifo_full_o  = full;
  assign fifo_count_o = count_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign overflow_o   = overflow_q;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Directed self-checking bench for gpa_fhdo_seq: vector table for word formatting and
// latency, plus hand-written sequences for overflow, timeout, SPI pacing, ADC and reset.
module tb_gpa_fhdo_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] grad_data_i;
  logic [1:0]  grad_ch_i;
  logic        grad_valid_i;
  logic        fifo_full_o;
  logic [4:0]  fifo_count_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_w;
  logic        adc_req_i;
  logic [23:0] adc_cmd_i;
  logic [15:0] adc_value_i;
  logic [15:0] adc_value_o;
  logic        adc_valid_o;
  logic        overflow_o;
  logic        timeout_o;
  logic        clr_err_i;

  logic        busy_man;
  logic        spi_auto;
  logic        spi_busy;
  logic [7:0]  spi_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mon_data [16];
  int          mon_n = 0;
  int          mon_vio = 0;

  always #5 clk = ~clk;

  assign busy_w = spi_auto ? spi_busy : busy_man;

  gpa_fhdo_seq dut (
    .clk(clk), .rst_n(rst_n),
    .grad_data_i(grad_data_i), .grad_ch_i(grad_ch_i), .grad_valid_i(grad_valid_i),
    .fifo_full_o(fifo_full_o), .fifo_count_o(fifo_count_o),
    .data_o(data_o), .valid_o(valid_o), .busy_i(busy_w),
    .adc_req_i(adc_req_i), .adc_cmd_i(adc_cmd_i), .adc_value_i(adc_value_i),
    .adc_value_o(adc_value_o), .adc_valid_o(adc_valid_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o), .clr_err_i(clr_err_i)
  );

  // SPI interface model: busy rises the cycle after valid and holds for 4 clocks x 8 bits.
  always @(posedge clk) begin
    if (!spi_auto) begin
      spi_busy <= 1'b0;
      spi_cnt  <= 8'd0;
    end else if (spi_busy) begin
      spi_cnt <= spi_cnt - 8'd1;
      if (spi_cnt == 8'd1) spi_busy <= 1'b0;
    end else if (valid_o) begin
      spi_busy <= 1'b1;
      spi_cnt  <= 8'd32;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      if (mon_n < 16) mon_data[mon_n] = data_o;
      mon_n = mon_n + 1;
      if (spi_auto && busy_w) mon_vio = mon_vio + 1;
    end
  end

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; grad_valid_i = 1'b0; grad_data_i = '0; grad_ch_i = '0;
    adc_req_i = 1'b0; adc_cmd_i = '0; adc_value_i = '0; clr_err_i = 1'b0;
    busy_man = 1'b0; spi_auto = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic write1(input logic [1:0] ch, input logic [15:0] d);
    grad_ch_i = ch; grad_data_i = d; grad_valid_i = 1'b1;
    tick();
    grad_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    int n = 0;
    while (valid_o !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    ok = (valid_o === 1'b1);
  endtask

  task automatic finish_xfer();
    busy_man = 1'b1; tick();
    busy_man = 1'b0; tick();
  endtask

  initial begin
    bit ok;
    int k;
    int base;
    int seen;
    logic [31:0] exp4 [3];

    vecs[0] = '{2'd2, 16'h0000, 32'h000A8000};
    vecs[1] = '{2'd0, 16'h8000, 32'h00080000};
    vecs[2] = '{2'd3, 16'h7FFF, 32'h000BFFFF};
    vecs[3] = '{2'd1, 16'h1234, 32'h00099234};
    vecs[4] = '{2'd0, 16'hFFFF, 32'h00087FFF};
    vecs[5] = '{2'd3, 16'hC001, 32'h000B4001};

    do_reset();
    check("rst_count", 32'(fifo_count_o), 0);
    check("rst_full", 32'(fifo_full_o), 0);
    check("rst_data", data_o, 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_flags", {30'd0, overflow_o, timeout_o}, 0);
    check("rst_adc", {15'd0, adc_valid_o, adc_value_o}, 0);

    // Vector table: format and write-to-valid latency (valid at N+3).
    for (int i = 0; i < 6; i++) begin
      write1(vecs[i].ch, vecs[i].data);
      check("vec_count_n1", 32'(fifo_count_o), 1);
      check("vec_valid_n1", 32'(valid_o), 0);
      tick();
      check("vec_valid_n2", 32'(valid_o), 0);
      tick();
      check("vec_valid_n3", 32'(valid_o), 1);
      check("vec_data", data_o, vecs[i].exp);
      $display("vec %0d ch=%0d data=%h -> word %h valid=%0b", i, vecs[i].ch, vecs[i].data, data_o, valid_o);
      tick();
      check("vec_valid_n4", 32'(valid_o), 0);
      check("vec_data_hold", data_o, vecs[i].exp);
      finish_xfer();
    end

    // 17 writes with busy held high: 16 stored, last dropped.
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write1(2'd1, 16'(i));
      if (i == 15) begin
        check("fill16_count", 32'(fifo_count_o), 16);
        check("fill16_full", 32'(fifo_full_o), 1);
        check("fill16_ovf", 32'(overflow_o), 0);
      end
    end
    $display("fill: count=%0d full=%0b overflow=%0b", fifo_count_o, fifo_full_o, overflow_o);
    check("fill17_count", 32'(fifo_count_o), 16);
    check("fill17_ovf", 32'(overflow_o), 1);
    clr_err_i = 1'b1; tick();
    check("ovf_clr", 32'(overflow_o), 0);
    grad_valid_i = 1'b1; tick();
    grad_valid_i = 1'b0;
    check("ovf_clr_vs_err", 32'(overflow_o), 1);
    tick();
    clr_err_i = 1'b0;
    check("ovf_clr2", 32'(overflow_o), 0);

    // Busy never rises: timeout, word dropped, FSM returns to IDLE.
    do_reset();
    write1(2'd1, 16'h0000);
    wait_valid(5, ok);
    check("tmo_first_valid", 32'(ok), 1);
    k = 0;
    while (timeout_o !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    $display("timeout: raised %0d cycles after valid", k);
    check("tmo_cycles", 32'(k), 256);
    write1(2'd2, 16'h0001);
    tick(); tick();
    check("tmo_next_valid", 32'(valid_o), 1);
    check("tmo_next_data", data_o, 32'h000A8001);
    check("tmo_sticky", 32'(timeout_o), 1);
    clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
    check("tmo_clr", 32'(timeout_o), 0);
    finish_xfer();

    // SPI model pacing with three queued words.
    do_reset();
    spi_auto = 1'b1;
    exp4[0] = 32'h00088001; exp4[1] = 32'h00098002; exp4[2] = 32'h000A8003;
    base = mon_n;
    k = mon_vio;
    write1(2'd0, 16'h0001);
    write1(2'd1, 16'h0002);
    write1(2'd2, 16'h0003);
    for (int c = 0; c < 300; c++) tick();
    seen = mon_n - base;
    check("spi_pulses", 32'(seen), 3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < 16) begin
        $display("spi word %0d = %h", i, mon_data[base + i]);
        check("spi_word", mon_data[base + i], exp4[i]);
      end
    end
    check("spi_no_valid_while_busy", 32'(mon_vio - k), 0);
    check("spi_drained", 32'(fifo_count_o), 0);

    // ADC request with a DAC word already queued.
    do_reset();
    busy_man = 1'b1;
    write1(2'd3, 16'h0005);
    adc_cmd_i = 24'h0A0000; adc_req_i = 1'b1; tick(); adc_req_i = 1'b0;
    busy_man = 1'b0;
    wait_valid(6, ok);
    check("adc_first_valid", 32'(ok), 1);
`ifdef GPA_FHDO_ADC_READBACK_EN
    check("adc_word", data_o, 32'h400A0000);
    busy_man = 1'b1; tick();
    adc_value_i = 16'h1234; busy_man = 1'b0; tick();
    check("adc_valid_pulse", 32'(adc_valid_o), 1);
    check("adc_value", 32'(adc_value_o), 32'h1234);
    tick();
    check("adc_valid_once", 32'(adc_valid_o), 0);
    wait_valid(6, ok);
    check("adc_then_dac", data_o, 32'h000B8005);
`else
    check("adc_ignored_word", data_o, 32'h000B8005);
    busy_man = 1'b1; tick();
    adc_value_i = 16'h1234; busy_man = 1'b0; tick();
    check("adc_ignored_valid", 32'(adc_valid_o), 0);
    check("adc_ignored_value", 32'(adc_value_o), 0);
    for (int c = 0; c < 6; c++) tick();
    check("adc_no_extra_issue", 32'(valid_o), 0);
`endif
    $display("adc: word=%h adc_value=%h", data_o, adc_value_o);
    finish_xfer();

    // Reset during WAIT_LO, then hold off until busy falls.
    do_reset();
    write1(2'd0, 16'h0010);
    write1(2'd1, 16'h0020);
    wait_valid(5, ok);
    check("rstlo_valid", 32'(ok), 1);
    busy_man = 1'b1; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rstlo_data", data_o, 0);
    check("rstlo_count", 32'(fifo_count_o), 0);
    check("rstlo_misc", {27'd0, valid_o, fifo_full_o, overflow_o, timeout_o, adc_valid_o}, 0);
    check("rstlo_adc", 32'(adc_value_o), 0);
    write1(2'd0, 16'h0100);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_o === 1'b1) k++;
    end
    check("rstlo_hold_off", 32'(k), 0);
    busy_man = 1'b0;
    wait_valid(6, ok);
    check("rstlo_resume", 32'(ok), 1);
    check("rstlo_data2", data_o, 32'h00088100);
    $display("reset-in-wait_lo: resumed word %h", data_o);
    finish_xfer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
